vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_vend_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending sequencer. Coins are accepted in IDLE, a buy or refund request is
// arbitrated there, a purchase is released in a single VEND cycle, and change
// is paid out greedily through a valid/ready coin dispenser in CHANGE.
module vend_sequencer #(
  parameter int PRICE0     = 25,
  parameter int PRICE1     = 50,
  parameter int PRICE2     = 75,
  parameter int PRICE3     = 90,
  parameter int CREDIT_MAX = 95
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Quarters,
  input  logic       Dimes,
  input  logic       Nickles,
  input  logic [3:0] Buy,
  input  logic       Refund,
  input  logic       DispReady,
  output logic       DispValid,
  output logic [1:0] DispCoin,
  output logic [3:0] Vending,
  output logic       CoinReject,
  output logic       Deny,
  output logic       Busy,
  output logic [6:0] Credit,
  output logic [3:0] QCnt,
  output logic [3:0] DCnt,
  output logic [3:0] NCnt
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_NICK = 2'b01;
  localparam logic [1:0] COIN_DIME = 2'b10;
  localparam logic [1:0] COIN_QTR  = 2'b11;

  state_t     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] qcnt_q, qcnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;
  logic [3:0] vending_q, vending_d;
  logic       reject_q, reject_d;
  logic       deny_q, deny_d;
  logic       disp_valid_q, disp_valid_d;
  logic [1:0] disp_coin_q, disp_coin_d;

  // Per-item price lookup.
  function automatic logic [6:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 7'(PRICE0);
      2'd1:    price_of = 7'(PRICE1);
      2'd2:    price_of = 7'(PRICE2);
      default: price_of = 7'(PRICE3);
    endcase
  endfunction

  // Largest coin not exceeding the given amount.
  function automatic logic [1:0] greedy(input logic [6:0] amt);
    if (amt >= 7'd25)      greedy = COIN_QTR;
    else if (amt >= 7'd10) greedy = COIN_DIME;
    else if (amt >= 7'd5)  greedy = COIN_NICK;
    else                   greedy = COIN_NONE;
  endfunction

  function automatic logic [6:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_QTR:  coin_value = 7'd25;
      COIN_DIME: coin_value = 7'd10;
      COIN_NICK: coin_value = 7'd5;
      default:   coin_value = 7'd0;
    endcase
  endfunction

  // Lowest-index set bit of the buy request.
  function automatic logic [1:0] lowest_idx(input logic [3:0] b);
    if (b[0])      lowest_idx = 2'd0;
    else if (b[1]) lowest_idx = 2'd1;
    else if (b[2]) lowest_idx = 2'd2;
    else           lowest_idx = 2'd3;
  endfunction

  logic       any_coin;
  logic       multi_coin;
  logic [6:0] in_value;
  logic [7:0] coin_sum;
  logic [1:0] buy_idx;

  assign any_coin   = Quarters | Dimes | Nickles;
  assign multi_coin = (Quarters & Dimes) | (Quarters & Nickles) | (Dimes & Nickles);
  assign in_value   = Quarters ? 7'd25 : (Dimes ? 7'd10 : (Nickles ? 7'd5 : 7'd0));
  assign coin_sum   = {1'b0, credit_q} + {1'b0, in_value};
  assign buy_idx    = lowest_idx(Buy);

  // Next-state, credit and output pulse computation.
  always_comb begin
    logic req_win;
    state_d   = state_q;
    credit_d  = credit_q;
    sel_d     = sel_q;
    qcnt_d    = qcnt_q;
    dcnt_d    = dcnt_q;
    ncnt_d    = ncnt_q;
    vending_d = 4'b0000;
    reject_d  = 1'b0;
    deny_d    = 1'b0;
    req_win   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Refund && credit_q != 7'd0) begin
          state_d = CHANGE;
          qcnt_d  = 4'd0;
          dcnt_d  = 4'd0;
          ncnt_d  = 4'd0;
          req_win = 1'b1;
        end else if (Buy != 4'b0000) begin
          if (credit_q >= price_of(buy_idx)) begin
            state_d   = VEND;
            sel_d     = buy_idx;
            vending_d = 4'b0001 << buy_idx;
            req_win   = 1'b1;
          end else begin
            deny_d = 1'b1;
          end
        end
        // A winning request takes the cycle; coins arriving with it bounce.
        if (any_coin) begin
          if (req_win || coin_sum > 8'(CREDIT_MAX)) begin
            reject_d = 1'b1;
          end else begin
            credit_d = coin_sum[6:0];
            reject_d = multi_coin;
          end
        end
      end
      VEND: begin
        reject_d = any_coin;
        credit_d = credit_q - price_of(sel_q);
        if (credit_d != 7'd0) begin
          state_d = CHANGE;
          qcnt_d  = 4'd0;
          dcnt_d  = 4'd0;
          ncnt_d  = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        reject_d = any_coin;
        if (disp_valid_q && DispReady) begin
          credit_d = credit_q - coin_value(disp_coin_q);
          case (disp_coin_q)
            COIN_QTR:  qcnt_d = qcnt_q + 4'd1;
            COIN_DIME: dcnt_d = dcnt_q + 4'd1;
            COIN_NICK: ncnt_d = ncnt_q + 4'd1;
            default:   ;
          endcase
          if (credit_d == 7'd0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dispenser offer follows the next state and next credit, so it is held
    // stable across stalls and recomputed right after each accepted coin.
    disp_valid_d = (state_d == CHANGE);
    disp_coin_d  = disp_valid_d ? greedy(credit_d) : COIN_NONE;
  end

  // State and registered outputs; reset abandons any change in progress.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      credit_q     <= 7'd0;
      sel_q        <= 2'd0;
      qcnt_q       <= 4'd0;
      dcnt_q       <= 4'd0;
      ncnt_q       <= 4'd0;
      vending_q    <= 4'b0000;
      reject_q     <= 1'b0;
      deny_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_coin_q  <= COIN_NONE;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      sel_q        <= sel_d;
      qcnt_q       <= qcnt_d;
      dcnt_q       <= dcnt_d;
      ncnt_q       <= ncnt_d;
      vending_q    <= vending_d;
      reject_q     <= reject_d;
      deny_q       <= deny_d;
      disp_valid_q <= disp_valid_d;
      disp_coin_q  <= disp_coin_d;
    end
  end

  assign Busy       = (state_q != IDLE);
  assign Credit     = credit_q;
  assign QCnt       = qcnt_q;
  assign DCnt       = dcnt_q;
  assign NCnt       = ncnt_q;
  assign Vending    = vending_q;
  assign CoinReject = reject_q;
  assign Deny       = deny_q;
  assign DispValid  = disp_valid_q;
  assign DispCoin   = disp_coin_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus a randomized
// transaction-level run against a credit/change model.
module tb_vend_sequencer;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Quarters = 1'b0, Dimes = 1'b0, Nickles = 1'b0;
  logic [3:0] Buy = 4'b0000;
  logic       Refund = 1'b0, DispReady = 1'b0;
  logic       DispValid, CoinReject, Deny, Busy;
  logic [1:0] DispCoin;
  logic [3:0] Vending, QCnt, DCnt, NCnt;
  logic [6:0] Credit;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  vend_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Quarters(Quarters), .Dimes(Dimes),
    .Nickles(Nickles), .Buy(Buy), .Refund(Refund), .DispReady(DispReady),
    .DispValid(DispValid), .DispCoin(DispCoin), .Vending(Vending),
    .CoinReject(CoinReject), .Deny(Deny), .Busy(Busy), .Credit(Credit),
    .QCnt(QCnt), .DCnt(DCnt), .NCnt(NCnt)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic coin(input logic q, input logic d, input logic n);
    Quarters = q; Dimes = d; Nickles = n;
    tick();
    Quarters = 1'b0; Dimes = 1'b0; Nickles = 1'b0;
  endtask

  function automatic int price(input int i);
    case (i)
      0: return 25;
      1: return 50;
      2: return 75;
      default: return 90;
    endcase
  endfunction

  function automatic int value_of(input logic [1:0] c);
    case (c)
      2'b11: return 25;
      2'b10: return 10;
      2'b01: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) tick();
    tests++; if ({DispValid, DispCoin, Vending, CoinReject, Deny, Busy} !== 10'd0) begin fails++; $display("FAIL reset_outputs got %b exp 0", {DispValid, DispCoin, Vending, CoinReject, Deny, Busy}); end
    tests++; if ({Credit, QCnt, DCnt, NCnt} !== 19'd0) begin fails++; $display("FAIL reset_regs got credit %0d q %0d d %0d n %0d exp 0", Credit, QCnt, DCnt, NCnt); end
    #4 Reset = 1'b1;
    tick();
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got %b exp 0", Busy); end
  endtask

  task automatic test_buy_change();
    coin(1, 0, 0); coin(1, 0, 0); coin(0, 1, 0);
    tests++; if (Credit !== 7'd60) begin fails++; $display("FAIL buy_credit60 got %0d exp 60", Credit); end
    DispReady = 1'b1; Buy = 4'b0010;
    tick();
    Buy = 4'b0000;
    tests++; if (Vending !== 4'b0010 || Busy !== 1'b1) begin fails++; $display("FAIL buy_vending got %b busy %b exp 0010 busy 1", Vending, Busy); end
    tick();
    tests++; if (Vending !== 4'b0000 || Credit !== 7'd10 || DispValid !== 1'b1 || DispCoin !== 2'b10) begin fails++; $display("FAIL buy_change_offer got vend %b credit %0d valid %b coin %b exp 0000 10 1 10", Vending, Credit, DispValid, DispCoin); end
    tick();
    tests++; if (Credit !== 7'd0 || Busy !== 1'b0 || DispValid !== 1'b0 || DispCoin !== 2'b00) begin fails++; $display("FAIL buy_done got credit %0d busy %b valid %b coin %b exp 0 0 0 00", Credit, Busy, DispValid, DispCoin); end
    tests++; if (QCnt !== 4'd0 || DCnt !== 4'd1 || NCnt !== 4'd0) begin fails++; $display("FAIL buy_counts got %0d/%0d/%0d exp 0/1/0", QCnt, DCnt, NCnt); end
    DispReady = 1'b0;
  endtask

  task automatic test_refund_full();
    logic [1:0] exp_seq [5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
    coin(1, 0, 0); coin(1, 0, 0); coin(1, 0, 0); coin(0, 1, 0); coin(0, 1, 0);
    tests++; if (Credit !== 7'd95) begin fails++; $display("FAIL full_credit95 got %0d exp 95", Credit); end
    coin(0, 0, 1);
    tests++; if (CoinReject !== 1'b1 || Credit !== 7'd95) begin fails++; $display("FAIL full_overflow got rej %b credit %0d exp 1 95", CoinReject, Credit); end
    tick();
    tests++; if (CoinReject !== 1'b0) begin fails++; $display("FAIL full_reject_pulse got %b exp 0", CoinReject); end
    DispReady = 1'b1; Refund = 1'b1;
    tick();
    Refund = 1'b0;
    tests++; if (QCnt !== 4'd0 || DCnt !== 4'd0 || NCnt !== 4'd0 || Busy !== 1'b1) begin fails++; $display("FAIL full_entry got cnt %0d/%0d/%0d busy %b exp 0/0/0 1", QCnt, DCnt, NCnt, Busy); end
    for (int k = 0; k < 5; k++) begin
      tests++; if (DispValid !== 1'b1 || DispCoin !== exp_seq[k]) begin fails++; $display("FAIL full_coin%0d got valid %b coin %b exp 1 %b", k, DispValid, DispCoin, exp_seq[k]); end
      tick();
    end
    tests++; if (Credit !== 7'd0 || Busy !== 1'b0 || QCnt !== 4'd3 || DCnt !== 4'd2 || NCnt !== 4'd0) begin fails++; $display("FAIL full_done got credit %0d busy %b cnt %0d/%0d/%0d exp 0 0 3/2/0", Credit, Busy, QCnt, DCnt, NCnt); end
    DispReady = 1'b0;
  endtask

  task automatic test_deny();
    coin(0, 1, 0); coin(0, 1, 0);
    Buy = 4'b0001;
    tick();
    Buy = 4'b0000;
    tests++; if (Deny !== 1'b1 || Vending !== 4'b0000 || Credit !== 7'd20 || Busy !== 1'b0) begin fails++; $display("FAIL deny_pulse got deny %b vend %b credit %0d busy %b exp 1 0000 20 0", Deny, Vending, Credit, Busy); end
    tick();
    tests++; if (Deny !== 1'b0) begin fails++; $display("FAIL deny_one_cycle got %b exp 0", Deny); end
    coin(0, 0, 1);
    Buy = 4'b1111;
    tick();
    Buy = 4'b0000;
    tests++; if (Vending !== 4'b0001) begin fails++; $display("FAIL deny_lowest_bit got %b exp 0001", Vending); end
    tick();
    tests++; if (Credit !== 7'd0 || Busy !== 1'b0 || Vending !== 4'b0000 || DispValid !== 1'b0) begin fails++; $display("FAIL deny_exact got credit %0d busy %b vend %b valid %b exp 0 0 0000 0", Credit, Busy, Vending, DispValid); end
  endtask

  task automatic test_coin_priority();
    coin(1, 0, 1);
    tests++; if (Credit !== 7'd25 || CoinReject !== 1'b1) begin fails++; $display("FAIL prio_qn got credit %0d rej %b exp 25 1", Credit, CoinReject); end
    coin(0, 1, 0);
    tests++; if (CoinReject !== 1'b0 || Credit !== 7'd35) begin fails++; $display("FAIL prio_dime got rej %b credit %0d exp 0 35", CoinReject, Credit); end
    DispReady = 1'b0; Refund = 1'b1;
    tick();
    Refund = 1'b0;
    coin(0, 1, 0);
    tests++; if (CoinReject !== 1'b1 || Credit !== 7'd35 || DispCoin !== 2'b11) begin fails++; $display("FAIL prio_change_dime got rej %b credit %0d coin %b exp 1 35 11", CoinReject, Credit, DispCoin); end
    DispReady = 1'b1;
    tick(); tick();
    tests++; if (Credit !== 7'd0 || Busy !== 1'b0 || QCnt !== 4'd1 || DCnt !== 4'd1) begin fails++; $display("FAIL prio_drain got credit %0d busy %b q %0d d %0d exp 0 0 1 1", Credit, Busy, QCnt, DCnt); end
    DispReady = 1'b0;
  endtask

  task automatic test_stall();
    coin(0, 1, 0); coin(0, 0, 1);
    DispReady = 1'b0; Refund = 1'b1;
    tick();
    Refund = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (DispValid !== 1'b1 || DispCoin !== 2'b10 || Credit !== 7'd15) begin fails++; $display("FAIL stall_hold%0d got valid %b coin %b credit %0d exp 1 10 15", k, DispValid, DispCoin, Credit); end
      tick();
    end
    DispReady = 1'b1;
    tick();
    tests++; if (Credit !== 7'd5 || DispCoin !== 2'b01 || DispValid !== 1'b1) begin fails++; $display("FAIL stall_dime got credit %0d coin %b valid %b exp 5 01 1", Credit, DispCoin, DispValid); end
    tick();
    tests++; if (Credit !== 7'd0 || Busy !== 1'b0 || DispValid !== 1'b0 || DCnt !== 4'd1 || NCnt !== 4'd1) begin fails++; $display("FAIL stall_done got credit %0d busy %b valid %b d %0d n %0d exp 0 0 0 1 1", Credit, Busy, DispValid, DCnt, NCnt); end
    DispReady = 1'b0;
  endtask

  task automatic test_reset_mid_change();
    coin(1, 0, 0); coin(1, 0, 0);
    Refund = 1'b1;
    tick();
    Refund = 1'b0;
    DispReady = 1'b1;
    tick();
    DispReady = 1'b0;
    tests++; if (Credit !== 7'd25 || Busy !== 1'b1) begin fails++; $display("FAIL rstmid_pre got credit %0d busy %b exp 25 1", Credit, Busy); end
    #3 Reset = 1'b0;
    #1;
    tests++; if ({DispValid, DispCoin, Vending, CoinReject, Deny, Busy} !== 10'd0 || Credit !== 7'd0 || QCnt !== 4'd0) begin fails++; $display("FAIL rstmid_async got outs %b credit %0d q %0d exp 0 0 0", {DispValid, DispCoin, Vending, CoinReject, Deny, Busy}, Credit, QCnt); end
    tick();
    #4 Reset = 1'b1;
    tick();
    tests++; if (DispValid !== 1'b0 || Busy !== 1'b0 || Credit !== 7'd0) begin fails++; $display("FAIL rstmid_release got valid %b busy %b credit %0d exp 0 0 0", DispValid, Busy, Credit); end
    coin(0, 0, 1);
    tests++; if (Credit !== 7'd5) begin fails++; $display("FAIL rstmid_nickel got %0d exp 5", Credit); end
  endtask

  // Randomized transactions: coin, buy or refund, each followed by the full
  // change payout with random dispenser stalls.
  task automatic test_random();
    int         m_credit, kind, idx, val, chg, nq, nd, nn, budget;
    logic [2:0] s;
    logic [3:0] b;
    logic       rdy, exp_rej;
    logic [1:0] cq[$];
    Reset = 1'b0; #3; Reset = 1'b1;
    tick();
    m_credit = 0;
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 9));
      chg = 0;
      if (kind < 5) begin
        s = 3'($urandom_range(1, 7));
        val = s[2] ? 25 : (s[1] ? 10 : 5);
        exp_rej = ($countones(s) > 1) || (m_credit + val > 95);
        if (m_credit + val <= 95) m_credit += val;
        coin(s[2], s[1], s[0]);
        tests++; if (Credit !== 7'(m_credit) || CoinReject !== exp_rej) begin fails++; $display("FAIL rnd_coin t%0d got credit %0d rej %b exp %0d %b", t, Credit, CoinReject, m_credit, exp_rej); end
      end else if (kind < 8) begin
        b = 4'($urandom_range(1, 15));
        idx = 0;
        while (!b[idx]) idx++;
        if (m_credit >= price(idx)) begin
          s = 3'($urandom_range(0, 7));
          Buy = b; {Quarters, Dimes, Nickles} = s;
          tick();
          Buy = 4'b0000; {Quarters, Dimes, Nickles} = 3'b000;
          tests++; if (Vending !== 4'(1 << idx) || CoinReject !== (s != 3'b000) || Credit !== 7'(m_credit) || Busy !== 1'b1) begin fails++; $display("FAIL rnd_vend t%0d got vend %b rej %b credit %0d exp %b %b %0d", t, Vending, CoinReject, Credit, 4'(1 << idx), (s != 3'b000), m_credit); end
          m_credit -= price(idx);
          tick();
          tests++; if (Credit !== 7'(m_credit) || Vending !== 4'b0000 || Busy !== (m_credit != 0)) begin fails++; $display("FAIL rnd_after_vend t%0d got credit %0d vend %b busy %b exp %0d 0000 %b", t, Credit, Vending, Busy, m_credit, (m_credit != 0)); end
          chg = m_credit;
        end else begin
          Buy = b;
          tick();
          Buy = 4'b0000;
          tests++; if (Deny !== 1'b1 || Vending !== 4'b0000 || Credit !== 7'(m_credit) || Busy !== 1'b0) begin fails++; $display("FAIL rnd_deny t%0d got deny %b vend %b credit %0d exp 1 0000 %0d", t, Deny, Vending, Credit, m_credit); end
        end
      end else begin
        if (m_credit > 0) begin
          s = 3'($urandom_range(0, 7));
          Refund = 1'b1; {Quarters, Dimes, Nickles} = s;
          tick();
          Refund = 1'b0; {Quarters, Dimes, Nickles} = 3'b000;
          tests++; if (Busy !== 1'b1 || CoinReject !== (s != 3'b000) || {QCnt, DCnt, NCnt} !== 12'd0 || Credit !== 7'(m_credit)) begin fails++; $display("FAIL rnd_refund t%0d got busy %b rej %b cnt %0d/%0d/%0d credit %0d exp 1 %b 0/0/0 %0d", t, Busy, CoinReject, QCnt, DCnt, NCnt, Credit, (s != 3'b000), m_credit); end
          chg = m_credit;
        end else begin
          Refund = 1'b1;
          tick();
          Refund = 1'b0;
          tests++; if (Busy !== 1'b0 || Credit !== 7'd0 || DispValid !== 1'b0) begin fails++; $display("FAIL rnd_refund0 t%0d got busy %b credit %0d valid %b exp 0 0 0", t, Busy, Credit, DispValid); end
        end
      end
      if (chg > 0) begin
        nq = chg / 25;
        nd = (chg % 25) / 10;
        nn = ((chg % 25) % 10) / 5;
        cq.delete();
        repeat (nq) cq.push_back(2'b11);
        repeat (nd) cq.push_back(2'b10);
        repeat (nn) cq.push_back(2'b01);
        budget = 0;
        while (cq.size() > 0 && budget < 300) begin
          tests++; if (DispValid !== 1'b1 || DispCoin !== cq[0]) begin fails++; $display("FAIL rnd_offer t%0d got valid %b coin %b exp 1 %b", t, DispValid, DispCoin, cq[0]); end
          rdy = 1'($urandom_range(0, 1));
          if (budget > 200) rdy = 1'b1;
          DispReady = rdy;
          tick();
          budget++;
          if (rdy) begin
            m_credit -= value_of(cq[0]);
            void'(cq.pop_front());
          end
          tests++; if (Credit !== 7'(m_credit)) begin fails++; $display("FAIL rnd_pay t%0d got credit %0d exp %0d", t, Credit, m_credit); end
        end
        DispReady = 1'b0;
        tests++; if (cq.size() != 0) begin fails++; $display("FAIL rnd_timeout t%0d got %0d coins left exp 0", t, cq.size()); end
        tests++; if (Busy !== 1'b0 || DispValid !== 1'b0 || DispCoin !== 2'b00 || QCnt !== 4'(nq) || DCnt !== 4'(nd) || NCnt !== 4'(nn)) begin fails++; $display("FAIL rnd_done t%0d got busy %b valid %b coin %b cnt %0d/%0d/%0d exp 0 0 00 %0d/%0d/%0d", t, Busy, DispValid, DispCoin, QCnt, DCnt, NCnt, nq, nd, nn); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_buy_change();
    test_refund_full();
    test_deny();
    test_coin_priority();
    test_stall();
    test_reset_mid_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
